param_load_balancer: RTL and testbench

PARAM_LOAD_BALANCER -- requirements
Module: param_load_balancer

---
 rtl/param_load_balancer.sv | 156 +++++++++++++++
 tb/tb_param_load_balancer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_load_balancer.sv
// Load balancer: accepts a batch of task bits and dispatches one task per
// cycle to the least-loaded server that still has room. Per-server load
// counters retire work on done pulses; trigger/overload flag the load level.

// Per-server load counter: +1 on dispatch, -1 on done (ignored at zero).
module plb_server_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] load_o
);
    logic [CNT_W-1:0] load_q, load_d;
    logic             dec_ok;

    assign dec_ok = dec_i && (load_q != '0);

    // Net change: dispatch and a valid completion on the same edge cancel.
    always_comb begin
        load_d = load_q;
        if (inc_i && !dec_ok)
            load_d = load_q + CNT_W'(1);
        else if (!inc_i && dec_ok)
            load_d = load_q - CNT_W'(1);
    end

    // Load register.
    always_ff @(posedge clk) begin
        if (reset)
            load_q <= '0;
        else
            load_q <= load_d;
    end

    assign load_o = load_q;
endmodule

module param_load_balancer #(
    parameter int NUM_SERVERS = 4,
    parameter int TASK_W      = 8,
    parameter int CNT_W       = 4,
    parameter int CAP         = 7,
    parameter int TRIG_TH     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         task_valid,
    input  logic [TASK_W-1:0]            tasks,
    output logic                         task_ready,
    input  logic [NUM_SERVERS-1:0]       done,
    output logic [NUM_SERVERS*CNT_W-1:0] server_load,
    output logic                         assign_valid,
    output logic [2:0]                   assign_id,
    output logic [7:0]                   reject_cnt,
    output logic                         trigger,
    output logic                         overload
);
    localparam logic [CNT_W-1:0] CAP_L = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] TH_L  = CNT_W'(TRIG_TH);

    typedef enum logic {IDLE, DISPATCH} state_t;

    state_t                             state_q;
    logic [TASK_W-1:0]                  pend_q, pend_d;
    logic                               assign_valid_q;
    logic [2:0]                         assign_id_q;
    logic [7:0]                         reject_q;
    logic                               trigger_q, overload_q;

    logic [NUM_SERVERS-1:0][CNT_W-1:0]  load;
    logic [NUM_SERVERS-1:0]             inc;
    logic [NUM_SERVERS-1:0]             hit;
    logic                               dispatch;
    logic                               found;
    logic [2:0]                         tgt;
    logic [CNT_W-1:0]                   best;

    assign dispatch = (state_q == DISPATCH);

    // Retire the lowest pending bit each dispatch cycle.
    assign pend_d = pend_q & (pend_q - TASK_W'(1));

    // Pick the minimum load below CAP; strict '<' keeps the lowest index on ties.
    always_comb begin
        found = 1'b0;
        tgt   = '0;
        best  = '0;
        for (int k = 0; k < NUM_SERVERS; k++) begin
            if (load[k] < CAP_L && (!found || load[k] < best)) begin
                found = 1'b1;
                tgt   = 3'(k);
                best  = load[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_SERVERS; g++) begin : g_srv
        assign inc[g] = dispatch && found && (tgt == 3'(g));
        assign hit[g] = (load[g] >= TH_L);
        assign server_load[g*CNT_W +: CNT_W] = load[g];

        plb_server_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc_i  (inc[g]),
            .dec_i  (done[g]),
            .load_o (load[g])
        );
    end

    // Control FSM plus registered dispatch/reject/threshold outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pend_q         <= '0;
            assign_valid_q <= 1'b0;
            assign_id_q    <= '0;
            reject_q       <= '0;
            trigger_q      <= 1'b0;
            overload_q     <= 1'b0;
        end else begin
            trigger_q      <= |hit;
            overload_q     <= &hit;
            assign_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (task_valid && tasks != '0) begin
                        pend_q  <= tasks;
                        state_q <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    pend_q <= pend_d;
                    if (found) begin
                        assign_valid_q <= 1'b1;
                        assign_id_q    <= tgt;
                    end else if (reject_q != 8'hFF) begin
                        reject_q <= reject_q + 8'd1;
                    end
                    if (pend_d == '0)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign task_ready   = (state_q == IDLE);
    assign assign_valid = assign_valid_q;
    assign assign_id    = assign_id_q;
    assign reject_cnt   = reject_q;
    assign trigger      = trigger_q;
    assign overload     = overload_q;
endmodule

// File: tb/tb_param_load_balancer.sv
// Bench for param_load_balancer at default parameters: directed table,
// corner-case sequences and random traffic against a task-count model.
module tb_param_load_balancer;
    localparam int NS = 4;
    localparam int CAP = 7;
    localparam int TH = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        task_valid = 1'b0;
    logic [7:0]  tasks = '0;
    logic        task_ready;
    logic [3:0]  done = '0;
    logic [15:0] server_load;
    logic        assign_valid;
    logic [2:0]  assign_id;
    logic [7:0]  reject_cnt;
    logic        trigger;
    logic        overload;

    int checks = 0;
    int failures = 0;

    param_load_balancer dut (
        .clk          (clk),
        .reset        (reset),
        .task_valid   (task_valid),
        .tasks        (tasks),
        .task_ready   (task_ready),
        .done         (done),
        .server_load  (server_load),
        .assign_valid (assign_valid),
        .assign_id    (assign_id),
        .reject_cnt   (reject_cnt),
        .trigger      (trigger),
        .overload     (overload)
    );

    always #5 clk = ~clk;

    // Reference model: tracks only how many tasks remain, not which bits.
    int m_pending = 0;
    int m_load [NS];
    int m_rej = 0;
    bit m_av = 0;
    int m_id = 0;
    bit m_trig = 0;
    bit m_ovl = 0;

    task automatic model_edge(input logic r, input logic tv, input logic [7:0] tk, input logic [3:0] dn);
        int inc [NS];
        int best;
        bit nt, no;
        if (r) begin
            m_pending = 0; m_rej = 0; m_av = 0; m_id = 0; m_trig = 0; m_ovl = 0;
            for (int k = 0; k < NS; k++) m_load[k] = 0;
            return;
        end
        nt = 0; no = 1;
        for (int k = 0; k < NS; k++) begin
            inc[k] = 0;
            if (m_load[k] >= TH) nt = 1; else no = 0;
        end
        m_av = 0;
        if (m_pending > 0) begin
            best = -1;
            for (int k = 0; k < NS; k++)
                if (m_load[k] < CAP && (best < 0 || m_load[k] < m_load[best])) best = k;
            if (best >= 0) begin
                m_av = 1; m_id = best; inc[best] = 1;
            end else if (m_rej < 255) begin
                m_rej++;
            end
            m_pending--;
        end else if (tv && tk != 0) begin
            m_pending = $countones(tk);
        end
        for (int k = 0; k < NS; k++)
            m_load[k] = m_load[k] + inc[k] - ((dn[k] && m_load[k] > 0) ? 1 : 0);
        m_trig = nt;
        m_ovl = no;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic compare_model();
        logic [15:0] e;
        for (int k = 0; k < NS; k++) e[k*4 +: 4] = 4'(m_load[k]);
        chk("m_ready", task_ready, m_pending == 0);
        chk("m_load", server_load, e);
        chk("m_av", assign_valid, m_av);
        if (m_av) chk("m_id", assign_id, m_id);
        chk("m_rej", reject_cnt, m_rej);
        chk("m_trig", trigger, m_trig);
        chk("m_ovl", overload, m_ovl);
    endtask

    // Drive inputs (called on a negedge), clock once, check on the next negedge.
    task automatic step(input logic r, input logic tv, input logic [7:0] tk, input logic [3:0] dn);
        reset = r; task_valid = tv; tasks = tk; done = dn;
        @(posedge clk);
        model_edge(r, tv, tk, dn);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    // Accept a batch, then stay through all its dispatch cycles.
    task automatic batch(input logic [7:0] tk);
        step(1'b0, 1'b1, tk, 4'h0);
        idle($countones(tk));
    endtask

    typedef struct {
        logic        r;
        logic        tv;
        logic [7:0]  tk;
        logic [3:0]  dn;
        logic        e_rdy;
        logic        e_av;
        logic [2:0]  e_id;
        logic [15:0] e_ld;
        logic [7:0]  e_rej;
        logic        e_trig;
        logic        e_ovl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, 8'h0F round-robin across empty servers, empty batch, done-all
        tbl[0] = '{1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h0F, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd0, 16'h0001, 8'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd1, 16'h0011, 8'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd2, 16'h0111, 8'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 3'd3, 16'h1111, 8'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 3'd0, 16'h1111, 8'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b0, 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0};

        for (int k = 0; k < NS; k++) m_load[k] = 0;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].tv, tbl[i].tk, tbl[i].dn);
            chk("t_ready", task_ready, tbl[i].e_rdy);
            chk("t_av", assign_valid, tbl[i].e_av);
            if (tbl[i].e_av) chk("t_id", assign_id, tbl[i].e_id);
            chk("t_load", server_load, tbl[i].e_ld);
            chk("t_rej", reject_cnt, tbl[i].e_rej);
            chk("t_trig", trigger, tbl[i].e_trig);
            chk("t_ovl", overload, tbl[i].e_ovl);
        end

        // Threshold flags lag the loads by one cycle.
        batch(8'h0F);
        step(1'b0, 1'b1, 8'hFF, 4'h0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 1'b0, 8'h00, 4'h0);
            chk("trig_lag", trigger, j >= 6);
            chk("ovl_pre", overload, 1'b0);
        end
        chk("load_3333", server_load, 16'h3333);
        idle(1);
        chk("ovl_lag", overload, 1'b1);

        // Tie-break: {2,1,1,3} -> server 1.
        step(1'b0, 1'b0, 8'h00, 4'b0111);
        step(1'b0, 1'b0, 8'h00, 4'b0110);
        chk("load_2113", server_load, 16'h3112);
        step(1'b0, 1'b1, 8'h01, 4'h0);
        step(1'b0, 1'b0, 8'h00, 4'h0);
        chk("tie_av", assign_valid, 1'b1);
        chk("tie_id", assign_id, 3'd1);
        chk("tie_load", server_load, 16'h3122);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 4'hF);

        // All servers full: whole batch rejected, loads untouched.
        for (int i = 0; i < 3; i++) batch(8'hFF);
        batch(8'h0F);
        chk("load_full", server_load, 16'h7777);
        step(1'b0, 1'b1, 8'h07, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 4'h0);
            chk("rej_av", assign_valid, 1'b0);
        end
        chk("rej_cnt3", reject_cnt, 8'd3);
        chk("rej_load", server_load, 16'h7777);

        // Dispatch and done to the same server cancel.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 4'b0010);
        chk("load_7727", server_load, 16'h7727);
        step(1'b0, 1'b1, 8'h01, 4'h0);
        step(1'b0, 1'b0, 8'h00, 4'b0010);
        chk("same_av", assign_valid, 1'b1);
        chk("same_id", assign_id, 3'd1);
        chk("same_load", server_load, 16'h7727);

        // Reject counter saturates at 255.
        for (int i = 0; i < 33; i++) batch(8'hFF);
        chk("rej_sat", reject_cnt, 8'd255);

        // done on an empty server is ignored.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 4'hF);
        step(1'b0, 1'b0, 8'h00, 4'b0100);
        chk("done_zero", server_load, 16'h0000);

        // Reset mid-batch wins over task_valid and done.
        step(1'b0, 1'b1, 8'hFF, 4'h0);
        step(1'b0, 1'b0, 8'h00, 4'h0);
        chk("mid_av", assign_valid, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 4'hF);
        chk("rst_ready", task_ready, 1'b1);
        chk("rst_load", server_load, 16'h0000);
        chk("rst_rej", reject_cnt, 8'd0);
        chk("rst_av", assign_valid, 1'b0);
        idle(1);
        chk("rst_idle_ready", task_ready, 1'b1);
        chk("rst_idle_av", assign_valid, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic       r, tv;
            logic [7:0] tk;
            logic [3:0] dn;
            r  = ($urandom_range(0, 99) == 0);
            tv = $urandom_range(0, 1);
            tk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            dn = 4'($urandom) & 4'($urandom);
            step(r, tv, tk, dn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
